timer_dev: RTL and testbench



---
 rtl/timer_dev.sv | 159 +++++++++++++++
 tb/tb_timer_dev.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// Memory-mapped programmable interval timer with one-shot and auto-reload modes.
// Optional 8-bit tick prescaler at word 3, enabled by defining TIMER_PRESCALE_EN.
module timer_dev #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  Addr,
  input  logic [31:0] Din,
  input  logic        We,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           ctrl_q, ctrl_d;
  logic [COUNT_W-1:0]   preset_q, preset_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 irq_pend_q, irq_pend_d;
  logic                 tick;

  logic                 wr_ctrl, wr_preset, en, mode_reload;

  assign wr_ctrl     = We && (Addr == 2'd0);
  assign wr_preset   = We && (Addr == 2'd1);
  assign en          = ctrl_q[0];
  assign mode_reload = (ctrl_q[2:1] == 2'b01);

`ifdef TIMER_PRESCALE_EN
  logic [7:0] prescale_q, prescale_d;
  logic [7:0] psc_cnt_q, psc_cnt_d;
  logic       wr_psc;

  assign wr_psc = We && (Addr == 2'd3);
  assign tick   = (psc_cnt_q == prescale_q);

  always_comb begin
    prescale_d = prescale_q;
    psc_cnt_d  = psc_cnt_q;
    if (wr_psc) begin
      prescale_d = Din[7:0];
    end
    if ((state_q == S_IDLE) || (state_q == S_LOAD)) begin
      psc_cnt_d = '0;
    end else if ((state_q == S_CNT) && en) begin
      psc_cnt_d = tick ? 8'd0 : psc_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale_q <= '0;
      psc_cnt_q  <= '0;
    end else begin
      prescale_q <= prescale_d;
      psc_cnt_q  <= psc_cnt_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_pend_d = irq_pend_q;

    if (wr_preset) begin
      preset_d = Din[COUNT_W-1:0];
    end
    // One-shot acknowledge; a new expiry at the same edge overrides it below.
    if (!mode_reload && (wr_ctrl || wr_preset)) begin
      irq_pend_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (count_q > COUNT_W'(1)) begin
            count_d = count_q - COUNT_W'(1);
          end else begin
            count_d    = '0;
            irq_pend_d = 1'b1;
            state_d    = S_INT;
          end
        end
      end
      S_INT: begin
        if (mode_reload) begin
          irq_pend_d = 1'b0;
          state_d    = S_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Applied last so a CTRL write beats the one-shot enable clear.
    if (wr_ctrl) begin
      ctrl_d = Din[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign IRQ = irq_pend_q & ctrl_q[3];

  always_comb begin
    Dout = '0;
    unique case (Addr)
      2'd0: Dout = {28'd0, ctrl_q};
      2'd1: Dout = 32'(preset_q);
      2'd2: Dout = 32'(count_q);
`ifdef TIMER_PRESCALE_EN
      2'd3: Dout = {24'd0, prescale_q};
`else
      2'd3: Dout = '0;
`endif
      default: Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: per-scenario tasks with a per-cycle
// scoreboard of expected IRQ/COUNT values.
module tb_timer_dev;

  logic        clk;
  logic        rst;
  logic [1:0]  Addr;
  logic [31:0] Din;
  logic        We;
  logic [31:0] Dout;
  logic        IRQ;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        irq;
    logic        chk;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  timer_dev #(.COUNT_W(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .Addr (Addr),
    .Din  (Din),
    .We   (We),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    We   = 1'b1;
    @(posedge clk);
    #1;
    We   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = Dout;
  endtask

  task automatic sample(output logic irq_s, output logic [31:0] cnt_s);
    @(negedge clk);
    Addr = 2'd2;
    #1;
    irq_s = IRQ;
    cnt_s = Dout;
  endtask

  function automatic void push_exp(input logic irq, input logic chk, input logic [31:0] cnt);
    exp_t e;
    e.irq = irq;
    e.chk = chk;
    e.cnt = cnt;
    sb.push_back(e);
  endfunction

  task automatic test_reset;
    logic [31:0] d;
    logic        irq_s;
    logic [31:0] cnt_s;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL reset_read addr %0d: got %h expected 0", a, d);
      end
    end
    checks++;
    if (IRQ !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %b expected 0", IRQ);
    end
    // Start a count, abort it with reset at COUNT=5.
    bus_write(2'd1, 32'd10);
    bus_write(2'd0, 32'h9);
    for (int i = 0; i < 8; i++) sample(irq_s, cnt_s);
    checks++;
    if (cnt_s !== 32'd5) begin
      errors++;
      $display("FAIL reset_precount: got %0d expected 5", cnt_s);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (IRQ !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_irq: got %b expected 0", IRQ);
    end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL reset_mid_read addr %0d: got %h expected 0", a, d);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) push_exp(1'b0, 1'b1, 32'd0);
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      sample(irq_s, cnt_s);
      e = sb.pop_front();
      checks++;
      if (irq_s !== e.irq || cnt_s !== e.cnt) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got irq=%b cnt=%0d expected irq=%b cnt=%0d",
                 i, irq_s, cnt_s, e.irq, e.cnt);
      end
    end
  endtask

  task automatic test_oneshot;
    logic        irq_s;
    logic [31:0] cnt_s;
    logic [31:0] d;
    bus_write(2'd1, 32'd4);
    bus_write(2'd0, 32'h9);
    for (int i = 0; i < 10; i++)
      push_exp(i >= 6, i >= 2, (i >= 2 && i <= 6) ? 32'(6 - i) : 32'd0);
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      sample(irq_s, cnt_s);
      e = sb.pop_front();
      checks++;
      if (irq_s !== e.irq || (e.chk && cnt_s !== e.cnt)) begin
        errors++;
        $display("FAIL oneshot cyc %0d: got irq=%b cnt=%0d expected irq=%b cnt=%0d",
                 i, irq_s, cnt_s, e.irq, e.cnt);
      end
    end
    rd(2'd0, d);
    checks++;
    if (d !== 32'h8) begin
      errors++;
      $display("FAIL oneshot_ctrl: got %h expected 8", d);
    end
    bus_write(2'd0, 32'h8);
    for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b1, 32'd0);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      sample(irq_s, cnt_s);
      e = sb.pop_front();
      checks++;
      if (irq_s !== e.irq || cnt_s !== e.cnt) begin
        errors++;
        $display("FAIL oneshot_ack cyc %0d: got irq=%b cnt=%0d expected irq=%b cnt=%0d",
                 i, irq_s, cnt_s, e.irq, e.cnt);
      end
    end
  endtask

  task automatic test_autoreload;
    logic        irq_s;
    logic [31:0] cnt_s;
    logic [31:0] seq [5];
    seq[0] = 32'd3; seq[1] = 32'd2; seq[2] = 32'd1; seq[3] = 32'd0; seq[4] = 32'd0;
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'hB);
    for (int i = 0; i < 22; i++) begin
      if (i < 2) push_exp(1'b0, 1'b0, 32'd0);
      else       push_exp(((i - 2) % 5) == 3, 1'b1, seq[(i - 2) % 5]);
    end
    for (int i = 0; i < 22; i++) begin
      exp_t e;
      sample(irq_s, cnt_s);
      e = sb.pop_front();
      checks++;
      if (irq_s !== e.irq || (e.chk && cnt_s !== e.cnt)) begin
        errors++;
        $display("FAIL autoreload cyc %0d: got irq=%b cnt=%0d expected irq=%b cnt=%0d",
                 i, irq_s, cnt_s, e.irq, e.cnt);
      end
    end
    bus_write(2'd0, 32'h0);
    repeat (3) @(posedge clk);
  endtask

  task automatic test_mask_freeze;
    logic        irq_s;
    logic [31:0] cnt_s;
    logic [31:0] d;
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h1);
    for (int i = 0; i < 8; i++) push_exp(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      sample(irq_s, cnt_s);
      e = sb.pop_front();
      checks++;
      if (irq_s !== e.irq) begin
        errors++;
        $display("FAIL mask cyc %0d: got irq=%b expected %b", i, irq_s, e.irq);
      end
    end
    rd(2'd0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL mask_ctrl: got %h expected 0", d);
    end
    // Freeze: disable exactly at the edge where COUNT becomes 7.
    bus_write(2'd1, 32'd10);
    bus_write(2'd0, 32'h1);
    for (int i = 0; i < 5; i++) push_exp(1'b0, i >= 2, 32'(12 - i));
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      sample(irq_s, cnt_s);
      e = sb.pop_front();
      checks++;
      if (irq_s !== e.irq || (e.chk && cnt_s !== e.cnt)) begin
        errors++;
        $display("FAIL freeze_run cyc %0d: got irq=%b cnt=%0d expected irq=%b cnt=%0d",
                 i, irq_s, cnt_s, e.irq, e.cnt);
      end
    end
    bus_write(2'd0, 32'h0);
    for (int i = 0; i < 10; i++) push_exp(1'b0, 1'b1, 32'd7);
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      sample(irq_s, cnt_s);
      e = sb.pop_front();
      checks++;
      if (irq_s !== e.irq || cnt_s !== e.cnt) begin
        errors++;
        $display("FAIL freeze_hold cyc %0d: got irq=%b cnt=%0d expected irq=%b cnt=%0d",
                 i, irq_s, cnt_s, e.irq, e.cnt);
      end
    end
    bus_write(2'd2, 32'hFF);
    rd(2'd2, d);
    checks++;
    if (d !== 32'd7) begin
      errors++;
      $display("FAIL count_write: got %0d expected 7", d);
    end
  endtask

  task automatic test_edge_cases;
    logic        irq_s;
    logic [31:0] cnt_s;
    logic [31:0] d;
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'h9);
    for (int i = 0; i < 6; i++) push_exp(i >= 3, i >= 2, 32'd0);
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      sample(irq_s, cnt_s);
      e = sb.pop_front();
      checks++;
      if (irq_s !== e.irq || (e.chk && cnt_s !== e.cnt)) begin
        errors++;
        $display("FAIL preset0 cyc %0d: got irq=%b cnt=%0d expected irq=%b cnt=%0d",
                 i, irq_s, cnt_s, e.irq, e.cnt);
      end
    end
    bus_write(2'd0, 32'h8);
    sample(irq_s, cnt_s);
    checks++;
    if (irq_s !== 1'b0) begin
      errors++;
      $display("FAIL preset0_ack: got irq=%b expected 0", irq_s);
    end
    // PRESET rewritten mid-run only affects the next reload.
    bus_write(2'd1, 32'd20);
    bus_write(2'd0, 32'hB);
    for (int i = 0; i < 27; i++) begin
      if (i < 2)        push_exp(1'b0, 1'b0, 32'd0);
      else if (i <= 21) push_exp(1'b0, 1'b1, 32'(22 - i));
      else if (i <= 23) push_exp(i == 22, 1'b1, 32'd0);
      else              push_exp(1'b0, 1'b1, 32'(33 - i));
    end
    for (int i = 0; i < 27; i++) begin
      exp_t e;
      if (i == 6) bus_write(2'd1, 32'd9);
      sample(irq_s, cnt_s);
      e = sb.pop_front();
      checks++;
      if (irq_s !== e.irq || (e.chk && cnt_s !== e.cnt)) begin
        errors++;
        $display("FAIL preset_change cyc %0d: got irq=%b cnt=%0d expected irq=%b cnt=%0d",
                 i, irq_s, cnt_s, e.irq, e.cnt);
      end
    end
    bus_write(2'd0, 32'h0);
    rd(2'd1, d);
    checks++;
    if (d !== 32'd9) begin
      errors++;
      $display("FAIL preset_read: got %0d expected 9", d);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_prescale;
    logic        irq_s;
    logic [31:0] cnt_s;
    logic [31:0] d;
`ifdef TIMER_PRESCALE_EN
    bus_write(2'd3, 32'd3);
    rd(2'd3, d);
    checks++;
    if (d !== 32'd3) begin
      errors++;
      $display("FAIL prescale_read: got %0d expected 3", d);
    end
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h9);
    for (int i = 0; i < 13; i++)
      push_exp(i >= 10, i >= 2, (i < 6) ? 32'd2 : ((i < 10) ? 32'd1 : 32'd0));
    for (int i = 0; i < 13; i++) begin
      exp_t e;
      sample(irq_s, cnt_s);
      e = sb.pop_front();
      checks++;
      if (irq_s !== e.irq || (e.chk && cnt_s !== e.cnt)) begin
        errors++;
        $display("FAIL prescale cyc %0d: got irq=%b cnt=%0d expected irq=%b cnt=%0d",
                 i, irq_s, cnt_s, e.irq, e.cnt);
      end
    end
`else
    bus_write(2'd3, 32'd3);
    rd(2'd3, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL prescale_read: got %0d expected 0", d);
    end
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h9);
    for (int i = 0; i < 7; i++)
      push_exp(i >= 4, i >= 2, (i < 4) ? 32'(4 - i) : 32'd0);
    for (int i = 0; i < 7; i++) begin
      exp_t e;
      sample(irq_s, cnt_s);
      e = sb.pop_front();
      checks++;
      if (irq_s !== e.irq || (e.chk && cnt_s !== e.cnt)) begin
        errors++;
        $display("FAIL noprescale cyc %0d: got irq=%b cnt=%0d expected irq=%b cnt=%0d",
                 i, irq_s, cnt_s, e.irq, e.cnt);
      end
    end
`endif
    bus_write(2'd0, 32'h0);
  endtask

  initial begin
    rst  = 1'b0;
    We   = 1'b0;
    Addr = 2'd0;
    Din  = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    test_reset;
    test_oneshot;
    test_autoreload;
    test_mask_freeze;
    test_edge_cases;
    test_prescale;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
